// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: decode-stage hazard controller.
// Generates the control-unit bubble (stall), PC / IF-ID write enables and the
// fetch-side flush strobe for load-use hazards, taken-branch flush windows and
// the ecall halt. A saturating counter reports how many cycles were stalled.
// Optional feature macro: HAZARD_ECALL_HALT_EN (ecall in RUN freezes the core
// until reset). Without it ecall is an ordinary no-operand instruction.
// FLUSH_CYCLES must lie in 1..7 (3-bit window counter).

module hazard_stall_unit #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        ifidValid,
   input  logic        branchTaken,
   output logic        stall,
   output logic        pcWrite,
   output logic        ifidWrite,
   output logic        flush,
   output logic        halted,
   output logic [15:0] stallCnt
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned OPC_W  = 7;
   localparam int unsigned SCNT_W = 16;

   localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
`ifdef HAZARD_ECALL_HALT_EN
   localparam logic [OPC_W-1:0] OPC_ECALL  = 7'b1110011;
`endif

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [REG_W-1:0]    r_ex_rd;
   logic                r_ex_load;
   logic [SCNT_W-1:0]   r_stall_cnt;

   logic [OPC_W-1:0]    w_opcode;
   logic [REG_W-1:0]    w_rd;
   logic [REG_W-1:0]    w_rs1;
   logic [REG_W-1:0]    w_rs2;
   logic                w_uses_rs1;
   logic                w_uses_rs2;
   logic                w_is_load;
   logic                w_load_use;
   logic                w_issue;
   logic                w_ecall_halt;
   logic                w_unused_bits;

   // Instruction field extraction
   assign w_opcode      = instr[6:0];
   assign w_rd          = instr[11:7];
   assign w_rs1         = instr[19:15];
   assign w_rs2         = instr[24:20];
   assign w_unused_bits = ^{instr[31:25], instr[14:12]};

   // Source-register usage by opcode class
   always_comb begin
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      case (w_opcode)
         OPC_RTYPE,
         OPC_STORE,
         OPC_BRANCH: begin
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
         end
         OPC_LOAD,
         OPC_ITYPE: begin
            w_uses_rs1 = 1'b1;
         end
         default: begin
            w_uses_rs1 = 1'b0;
            w_uses_rs2 = 1'b0;
         end
      endcase
   end

   assign w_is_load = (w_opcode == OPC_LOAD);

   // Load in EX whose destination is read by the instruction in ID
   assign w_load_use = ifidValid & r_ex_load & (r_ex_rd != '0) &
                       ((w_uses_rs1 & (w_rs1 == r_ex_rd)) |
                        (w_uses_rs2 & (w_rs2 == r_ex_rd)));

   // Pipeline control outputs; stall never feeds back into its own inputs
   always_comb begin
      stall        = 1'b0;
      pcWrite      = 1'b1;
      ifidWrite    = 1'b1;
      flush        = 1'b0;
      w_ecall_halt = 1'b0;
      case (r_state)
         ST_HALT: begin
            stall     = 1'b1;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
         end
         ST_FLUSH: begin
            stall = 1'b1;
            flush = branchTaken;
         end
         default: begin
            if (branchTaken) begin
               stall = 1'b1;
               flush = 1'b1;
            end else if (w_load_use) begin
               stall     = 1'b1;
               pcWrite   = 1'b0;
               ifidWrite = 1'b0;
            end else begin
`ifdef HAZARD_ECALL_HALT_EN
               w_ecall_halt = ifidValid & (w_opcode == OPC_ECALL);
`else
               w_ecall_halt = 1'b0;
`endif
            end
         end
      endcase
   end

   // Instruction leaving ID this cycle (otherwise a bubble enters EX)
   assign w_issue = ifidValid & ~stall & ~flush;

   // State, flush window, EX-stage load tracking and stall statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_cnt       <= '0;
         r_ex_rd     <= '0;
         r_ex_load   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_ex_rd   <= w_issue ? w_rd : '0;
         r_ex_load <= w_issue & w_is_load;
         if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
         end
         case (r_state)
            ST_RUN: begin
               if (branchTaken) begin
                  r_state <= ST_FLUSH;
                  r_cnt   <= CNT_W'(FLUSH_CYCLES);
               end else if (w_ecall_halt) begin
                  r_state <= ST_HALT;
               end
            end
            ST_FLUSH: begin
               if (branchTaken) begin
                  r_cnt <= CNT_W'(FLUSH_CYCLES);
               end else if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign stallCnt = r_stall_cnt;

`ifdef HAZARD_ECALL_HALT_EN
   logic r_halted;

   // Halt flag, raised the cycle after ecall issues and held until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted <= 1'b0;
      end else if ((r_state == ST_RUN) && !branchTaken && w_ecall_halt) begin
         r_halted <= 1'b1;
      end
   end

   assign halted = r_halted;
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed vector table, multi-cycle corner
// sequences (ecall halt, reset mid-flush, counter saturation) and randomized
// stimulus checked against an instruction-history reference model.

module tb_hazard_stall_unit;

   localparam int unsigned FC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        ifidValid = 1'b0;
   logic        branchTaken = 1'b0;
   logic        stall, pcWrite, ifidWrite, flush, halted;
   logic [15:0] stallCnt;

   int n_cmp = 0;
   int n_bad = 0;

   hazard_stall_unit #(.FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .ifidValid(ifidValid),
      .branchTaken(branchTaken), .stall(stall), .pcWrite(pcWrite),
      .ifidWrite(ifidWrite), .flush(flush), .halted(halted), .stallCnt(stallCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      logic        v;
      logic        br;
      logic [3:0]  exp;   // {stall, pcWrite, ifidWrite, flush}
   } vec_t;

   vec_t tbl[20];

   localparam logic [31:0] LW_X5   = 32'h0000A283;
   localparam logic [31:0] ADD_X5  = 32'h00228333;
   localparam logic [31:0] LW_X0   = 32'h0000A003;
   localparam logic [31:0] ADD_X0  = 32'h00200333;
   localparam logic [31:0] ADDI_X1 = 32'h00108393;
   localparam logic [31:0] ECALL   = 32'h00000073;

   // reference model state
   logic [31:0] hist[$];     // what entered EX each cycle (0 = bubble)
   int          m_flush_left;
   bit          m_halt;
   int          m_cnt;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic v, input logic br);
      instr = ins; ifidValid = v; branchTaken = br;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; instr = '0; ifidValid = 1'b0; branchTaken = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hist.delete();
      m_flush_left = 0; m_halt = 0; m_cnt = 0;
   endtask

   function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
      logic [6:0] op;
      bit u1, u2;
      op = ins[6:0];
      u1 = (op == 7'h33) || (op == 7'h03) || (op == 7'h13) || (op == 7'h23) || (op == 7'h63);
      u2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
      return (u1 && ins[19:15] == r) || (u2 && ins[24:20] == r);
   endfunction

   // One model-checked cycle
   task automatic rstep(input logic [31:0] ins, input logic v, input logic br, input string nm);
      logic [31:0] prev;
      logic [3:0]  e;
      bit          lu, issued;
      drive(ins, v, br);
      prev = (hist.size() > 0) ? hist[$] : 32'h0;
      lu = v && (prev[6:0] == 7'h03) && (prev[11:7] != 5'd0) && reads_reg(ins, prev[11:7]);
      if (m_halt)                e = 4'b1000;
      else if (br)               e = 4'b1111;
      else if (m_flush_left > 0) e = 4'b1110;
      else if (lu)               e = 4'b1000;
      else                       e = 4'b0110;
      cmp({nm, ".ctl"}, 32'({stall, pcWrite, ifidWrite, flush}), 32'(e));
      cmp({nm, ".halted"}, 32'(halted), 32'(m_halt));
      cmp({nm, ".cnt"}, 32'(stallCnt), 32'(m_cnt));
      issued = v && !e[3] && !e[0];
      tick();
      if (e[3] && m_cnt < 65535) m_cnt++;
      hist.push_back(issued ? ins : 32'h0);
      if (hist.size() > 4) void'(hist.pop_front());
`ifdef HAZARD_ECALL_HALT_EN
      if (e == 4'b0110 && v && ins[6:0] == 7'h73) m_halt = 1;
`endif
      if (!m_halt || e != 4'b1000) begin
         if (br && !m_halt) m_flush_left = FC;
         else if (m_flush_left > 0) m_flush_left--;
      end
   endtask

   logic [6:0] pool[6];

   initial begin
      pool = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F};

      tbl[0]  = '{LW_X5,   1'b1, 1'b0, 4'b0110};
      tbl[1]  = '{ADD_X5,  1'b1, 1'b0, 4'b1000};   // load-use bubble
      tbl[2]  = '{ADD_X5,  1'b1, 1'b0, 4'b0110};   // add issues
      tbl[3]  = '{LW_X0,   1'b1, 1'b0, 4'b0110};
      tbl[4]  = '{ADD_X0,  1'b1, 1'b0, 4'b0110};   // x0 never hazards
      tbl[5]  = '{LW_X5,   1'b1, 1'b0, 4'b0110};
      tbl[6]  = '{ADDI_X1, 1'b1, 1'b0, 4'b0110};   // independent
      tbl[7]  = '{LW_X5,   1'b1, 1'b0, 4'b0110};
      tbl[8]  = '{ADD_X5,  1'b1, 1'b1, 4'b1111};   // branch beats load-use
      tbl[9]  = '{ADD_X5,  1'b1, 1'b0, 4'b1110};
      tbl[10] = '{ADD_X5,  1'b1, 1'b0, 4'b1110};
      tbl[11] = '{ADD_X5,  1'b1, 1'b0, 4'b0110};   // no extra bubble
      tbl[12] = '{LW_X5,   1'b0, 1'b0, 4'b0110};   // invalid load
      tbl[13] = '{ADD_X5,  1'b1, 1'b0, 4'b0110};
      tbl[14] = '{ADDI_X1, 1'b1, 1'b1, 4'b1111};
      tbl[15] = '{ADDI_X1, 1'b1, 1'b0, 4'b1110};
      tbl[16] = '{ADDI_X1, 1'b1, 1'b1, 4'b1111};   // reload in FLUSH
      tbl[17] = '{ADDI_X1, 1'b1, 1'b0, 4'b1110};
      tbl[18] = '{ADDI_X1, 1'b1, 1'b0, 4'b1110};
      tbl[19] = '{ADDI_X1, 1'b1, 1'b0, 4'b0110};

      // reset state
      #3;
      cmp("rst.ctl", 32'({stall, pcWrite, ifidWrite, flush}), 32'(4'b0110));
      cmp("rst.halted", 32'(halted), 32'd0);
      cmp("rst.cnt", 32'(stallCnt), 32'd0);
      do_reset();

      // directed vector table
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].ins, tbl[i].v, tbl[i].br);
         cmp($sformatf("vec%0d", i), 32'({stall, pcWrite, ifidWrite, flush}), 32'(tbl[i].exp));
         if (i == 3) cmp("vec.cnt_after_lu", 32'(stallCnt), 32'd1);
         if (i == 12) cmp("vec.cnt_after_br", 32'(stallCnt), 32'd4);
         tick();
      end
      drive(ADDI_X1, 1'b1, 1'b0);
      cmp("vec.cnt_end", 32'(stallCnt), 32'd9);

      // reset in the middle of a flush window
      drive(ADDI_X1, 1'b1, 1'b1);
      tick();
      drive(ADDI_X1, 1'b1, 1'b0);
      cmp("midflush.ctl", 32'({stall, pcWrite, ifidWrite, flush}), 32'(4'b1110));
      rst_n = 1'b0;
      #1;
      cmp("midflush.rst_ctl", 32'({stall, pcWrite, ifidWrite, flush}), 32'(4'b0110));
      cmp("midflush.rst_cnt", 32'(stallCnt), 32'd0);
      do_reset();

      // ecall
      drive(ECALL, 1'b1, 1'b0);
      cmp("ecall.issue", 32'({stall, pcWrite, ifidWrite, flush}), 32'(4'b0110));
      tick();
`ifdef HAZARD_ECALL_HALT_EN
      drive(ADD_X5, 1'b1, 1'b1);
      cmp("halt.halted", 32'(halted), 32'd1);
      cmp("halt.ctl", 32'({stall, pcWrite, ifidWrite, flush}), 32'(4'b1000));
      tick(); tick();
      cmp("halt.hold", 32'({halted, stall, pcWrite, ifidWrite, flush}), 32'(5'b11000));
      branchTaken = 1'b0;
      rst_n = 1'b0;
      #1;
      cmp("halt.rst", 32'({halted, stall, pcWrite, ifidWrite, flush}), 32'(5'b00110));
`else
      drive(ADD_X5, 1'b1, 1'b0);
      cmp("ecall.nohalt", 32'({halted, stall, pcWrite, ifidWrite, flush}), 32'(5'b00110));
      tick();
      cmp("ecall.nohalt2", 32'({halted, pcWrite}), 32'(2'b01));
`endif
      do_reset();

      // randomized stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ins;
         logic [6:0]  op;
         op  = pool[$urandom_range(0, 5)];
         ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
`ifndef HAZARD_ECALL_HALT_EN
         if ($urandom_range(0, 15) == 0) ins = ECALL;
`endif
         rstep(ins, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 11) == 0),
               $sformatf("rnd%0d", i));
      end

      // stall counter saturation (branch held continuously)
      do_reset();
      drive(ADDI_X1, 1'b1, 1'b1);
      for (int i = 0; i < 70000; i++) tick();
      #2;
      cmp("sat.cnt", 32'(stallCnt), 32'h0000FFFF);
      cmp("sat.stall", 32'(stall), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      #2;
      cmp("sat.hold", 32'(stallCnt), 32'h0000FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
